// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {GNT_CORE, GNT_DBG} grant_t;

  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the core/debug requesters, the arbiter and the data memory.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface dmem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_done;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_done;

  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_done, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done,
    output mem_wr, mem_rd, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_done, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done,
    input  mem_wr, mem_rd, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory port.
// DMEM_ARB_RR_EN defined: round-robin on contention; undefined: core has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   core_req_i,
  input  logic   dbg_req_i,
  input  grant_t last_gnt_i,
  output logic   valid_o,
  output grant_t gnt_o
);

  assign valid_o = core_req_i | dbg_req_i;

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    gnt_o = GNT_CORE;
    if (core_req_i && dbg_req_i) begin
      gnt_o = (last_gnt_i == GNT_CORE) ? GNT_DBG : GNT_CORE;
    end else if (dbg_req_i) begin
      gnt_o = GNT_DBG;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
  assign gnt_o = core_req_i ? GNT_CORE : GNT_DBG;
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core and the debug loader via an
// IDLE/ACCESS/WAIT/RESP sequencer. DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(RD_LAT_MAX);

  if (RD_LAT == 0 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dmem_port_arbiter: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
  end

  state_t            state_q, state_d;
  grant_t            owner_q, owner_d;
  grant_t            last_gnt, pick_gnt;
  logic              pick_valid;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  dmem_arb_pick u_pick (
    .core_req_i (bus.core_req),
    .dbg_req_i  (bus.dbg_req),
    .last_gnt_i (last_gnt),
    .valid_o    (pick_valid),
    .gnt_o      (pick_gnt)
  );

`ifdef DMEM_ARB_RR_EN
  grant_t last_gnt_q;

  // Reset to dbg so the core wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= GNT_DBG;
    end else if (state_q == IDLE && pick_valid) begin
      last_gnt_q <= pick_gnt;
    end
  end

  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = GNT_DBG;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_gnt;
          if (pick_gnt == GNT_CORE) begin
            we_d    = bus.core_we;
            addr_d  = bus.core_addr;
            wdata_d = bus.core_wdata;
          end else begin
            we_d    = bus.dbg_we;
            addr_d  = bus.dbg_addr;
            wdata_d = bus.dbg_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == GNT_CORE) core_rdata_d = bus.mem_rdata;
          else                     dbg_rdata_d  = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= GNT_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // addr_q only changes on a grant, so mem_addr holds its last value outside ACCESS.
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wr     = (state_q == ACCESS) && we_q;
  assign bus.mem_rd     = (state_q == ACCESS) && !we_q;
  assign bus.mem_wdata  = bus.mem_wr ? wdata_q : '0;
  assign bus.core_done  = (state_q == RESP) && (owner_q == GNT_CORE);
  assign bus.dbg_done   = (state_q == RESP) && (owner_q == GNT_DBG);
  assign bus.core_stall = bus.core_req & ~bus.core_done;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.busy       = (state_q != IDLE);

  logic owner_req;
  assign owner_req = (owner_q == GNT_CORE) ? bus.core_req : bus.dbg_req;

  req_held_a: assert property (@(posedge clk) disable iff (reset) (state_q != IDLE) |-> owner_req)
    else $error("dmem_port_arbiter: request dropped before done");

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations. DMEM_ARB_RR_EN selects the RR scenario.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 9;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  dmem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 9'h010) ? 32'h1234_5678 : {16'hC0DE, 7'd0, a};
  endfunction

  // Memory behind the main DUT: read data appears LAT cycles after mem_rd.
  logic [DW-1:0] mem_a [512];
  bit            mem_w [512];
  logic [DW-1:0] rd_pipe [LAT];

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    return mem_w[a] ? mem_a[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem_a[bus.mem_addr] <= bus.mem_wdata;
      mem_w[bus.mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= bus.mem_rd ? mem_read(bus.mem_addr) : 32'hBAD0_0000;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  logic [DW-1:0] rd1_q;
  always @(posedge clk) rd1_q <= bus1.mem_rd ? init_val(bus1.mem_addr) : 32'hBAD0_0000;
  assign bus1.mem_rdata = rd1_q;

  typedef struct {
    int            c;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } strobe_t;
  strobe_t strobe_q[$];

  always @(negedge clk) begin
    if (bus.mem_wr || bus.mem_rd)
      strobe_q.push_back('{cyc, bus.mem_wr, bus.mem_addr, bus.mem_wdata});
  end

  // Reference model: one transaction at a time, timed from its grant cycle.
  initial begin : model
    bit            active, rr, e_stb, e_done, e_busy, e_cd, e_dd;
    int            start, dur, off;
    grant_t        who, last;
    bit            m_we;
    logic [AW-1:0] m_addr, m_mem_addr;
    logic [DW-1:0] m_wdata, m_rd_val, m_core_rdata, m_dbg_rdata;
    logic [DW-1:0] ref_mem [512];
    bit            ref_w [512];
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    active = 1'b0; start = 0; dur = 0; last = GNT_DBG; who = GNT_CORE; m_we = 1'b0;
    m_addr = '0; m_mem_addr = '0; m_wdata = '0; m_rd_val = '0;
    m_core_rdata = '0; m_dbg_rdata = '0;
    forever begin
      @(negedge clk);
      off    = cyc - start;
      e_stb  = active && off == 1;
      e_done = active && off == dur;
      e_busy = active && off >= 1 && off <= dur;
      e_cd   = e_done && who == GNT_CORE;
      e_dd   = e_done && who == GNT_DBG;
      if (e_stb) begin
        m_mem_addr = m_addr;
        if (m_we) begin
          ref_mem[m_addr] = m_wdata;
          ref_w[m_addr]   = 1'b1;
        end
      end
      if (e_done && !m_we) begin
        if (who == GNT_CORE) m_core_rdata = m_rd_val;
        else                 m_dbg_rdata  = m_rd_val;
      end
      check("mem_wr",     bus.mem_wr,     e_stb && m_we);
      check("mem_rd",     bus.mem_rd,     e_stb && !m_we);
      check("mem_addr",   bus.mem_addr,   m_mem_addr);
      check("mem_wdata",  bus.mem_wdata,  (e_stb && m_we) ? m_wdata : '0);
      check("core_done",  bus.core_done,  e_cd);
      check("dbg_done",   bus.dbg_done,   e_dd);
      check("core_stall", bus.core_stall, bus.core_req && !e_cd);
      check("busy",       bus.busy,       e_busy);
      check("core_rdata", bus.core_rdata, m_core_rdata);
      check("dbg_rdata",  bus.dbg_rdata,  m_dbg_rdata);
      if (active && off >= dur) active = 1'b0;
      if (reset) begin
        active = 1'b0; last = GNT_DBG; m_mem_addr = '0;
        m_core_rdata = '0; m_dbg_rdata = '0;
      end else if (!e_busy && (bus.core_req || bus.dbg_req)) begin
        who = (bus.core_req && (!bus.dbg_req || !rr || last == GNT_DBG)) ? GNT_CORE : GNT_DBG;
        last    = who;
        m_we    = (who == GNT_CORE) ? bus.core_we    : bus.dbg_we;
        m_addr  = (who == GNT_CORE) ? bus.core_addr  : bus.dbg_addr;
        m_wdata = (who == GNT_CORE) ? bus.core_wdata : bus.dbg_wdata;
        m_rd_val = ref_w[m_addr] ? ref_mem[m_addr] : init_val(m_addr);
        dur    = m_we ? 2 : LAT + 2;
        start  = cyc;
        active = 1'b1;
      end
    end
  end

  // Called right after a rising edge; returns right after a rising edge with req dropped.
  task automatic txn(input bit is_core, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int t0, output int done_rel,
                     output int stall_cnt, output logic [DW-1:0] rdata);
    if (is_core) begin
      bus.core_we = we; bus.core_addr = a; bus.core_wdata = d; bus.core_req = 1'b1;
    end else begin
      bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d; bus.dbg_req = 1'b1;
    end
    t0 = cyc; done_rel = -1; stall_cnt = 0; rdata = 'x;
    for (int i = 0; i < 16 && done_rel < 0; i++) begin
      @(negedge clk);
      if (is_core && bus.core_stall) stall_cnt++;
      if (is_core ? bus.core_done : bus.dbg_done) begin
        done_rel = cyc - t0;
        rdata    = is_core ? bus.core_rdata : bus.dbg_rdata;
      end
    end
    @(posedge clk); #1;
    if (is_core) bus.core_req = 1'b0;
    else         bus.dbg_req  = 1'b0;
  endtask

  initial begin : stim
    int            t0, dr, st, t0b, drb, stb, base, n, dones;
    int            d_at [2];
    logic [DW-1:0] rd, rdb;
    logic [DW-1:0] d_val [2];
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req  = 0; bus.dbg_we  = 0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
    bus1.core_req = 0; bus1.core_we = 0; bus1.core_addr = '0; bus1.core_wdata = '0;
    bus1.dbg_req  = 0; bus1.dbg_we  = 0; bus1.dbg_addr  = '0; bus1.dbg_wdata  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy",       bus.busy,       0);
    check("rst_mem_addr",   bus.mem_addr,   0);
    check("rst_core_rdata", bus.core_rdata, 0);
    check("rst_dbg_rdata",  bus.dbg_rdata,  0);
    @(posedge clk); #1;

    // Core store 0x05 <= 0xDEADBEEF
    base = strobe_q.size();
    txn(1'b1, 1'b1, 9'h005, 32'hDEAD_BEEF, t0, dr, st, rd);
    check("t1_done_cycle", dr, 2);
    check("t1_stall_cycles", st, 2);
    check("t1_wr_cycle", strobe_q[base].c - t0, 1);
    check("t1_wr_addr", strobe_q[base].a, 9'h005);
    check("t1_wr_data", strobe_q[base].d, 32'hDEAD_BEEF);

    // Debug read-back of the stored word
    txn(1'b0, 1'b0, 9'h005, 32'h0, t0, dr, st, rd);
    check("rb_done_cycle", dr, 5);
    check("rb_rdata", rd, 32'hDEAD_BEEF);

    // Core load 0x10, RD_LAT=3
    base = strobe_q.size();
    txn(1'b1, 1'b0, 9'h010, 32'h0, t0, dr, st, rd);
    check("t2_rd_cycle", strobe_q[base].c - t0, 1);
    check("t2_rd_strobe", strobe_q[base].wr, 0);
    check("t2_done_cycle", dr, 5);
    check("t2_rdata", rd, 32'h1234_5678);
    check("t2_stall_cycles", st, 5);

`ifndef DMEM_ARB_RR_EN
    // Simultaneous writes, fixed priority: core first, dbg 3 cycles later
    base = strobe_q.size();
    fork
      txn(1'b1, 1'b1, 9'h020, 32'h1111_2222, t0, dr, st, rd);
      txn(1'b0, 1'b1, 9'h021, 32'h3333_4444, t0b, drb, stb, rdb);
    join
    check("t3_first_addr", strobe_q[base].a, 9'h020);
    check("t3_second_addr", strobe_q[base+1].a, 9'h021);
    check("t3_gap", strobe_q[base+1].c - strobe_q[base].c, 3);
    check("t3_core_done", dr, 2);
    check("t3_dbg_done", drb, 5);
`endif

    // Back-to-back dbg reads across the address wrap on the RD_LAT=1 instance
    bus1.dbg_we = 1'b0; bus1.dbg_addr = 9'h1FF; bus1.dbg_req = 1'b1;
    t0 = cyc; n = 0; d_at[0] = -1; d_at[1] = -1; d_val[0] = 'x; d_val[1] = 'x;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (bus1.dbg_done) begin
        d_at[n] = cyc - t0; d_val[n] = bus1.dbg_rdata; n++;
      end
      @(posedge clk); #1;
      if (n == 1) bus1.dbg_addr = 9'h000;
      if (n == 2) bus1.dbg_req = 1'b0;
    end
    bus1.dbg_req = 1'b0;
    check("t6_first_done", d_at[0], 3);
    check("t6_gap", d_at[1] - d_at[0], 4);
    check("t6_data_1ff", d_val[0], 32'hC0DE_01FF);
    check("t6_data_000", d_val[1], 32'hC0DE_0000);

    // Reset during a dbg read WAIT
    bus.dbg_we = 1'b0; bus.dbg_addr = 9'h030; bus.dbg_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_busy_in_wait", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    check("t5_busy", bus.busy, 0);
    check("t5_dbg_done", bus.dbg_done, 0);
    check("t5_mem_rd", bus.mem_rd, 0);
    check("t5_mem_addr", bus.mem_addr, 0);
    check("t5_dbg_rdata", bus.dbg_rdata, 0);
    check("t5_core_rdata", bus.core_rdata, 0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.dbg_done || bus.core_done) dones++;
    end
    check("t5_no_done", dones, 0);
    @(posedge clk); #1;

`ifdef DMEM_ARB_RR_EN
    // Continuous requests from both sides after reset: grants alternate, core first
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    base = strobe_q.size();
    fork
      for (int k = 0; k < 4; k++) txn(1'b1, 1'b1, 9'(9'h040 + k), 32'(k), t0, dr, st, rd);
      for (int k = 0; k < 4; k++) txn(1'b0, 1'b1, 9'(9'h050 + k), 32'(k), t0b, drb, stb, rdb);
    join
    for (int k = 0; k < 8; k++) begin
      check("t4_grant_order", strobe_q[base+k].a,
            (k % 2 == 0) ? 9'(9'h040 + k / 2) : 9'(9'h050 + k / 2));
      if (k > 0) check("t4_gap", strobe_q[base+k].c - strobe_q[base+k-1].c, 3);
    end
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
